sha256_ctrl: RTL
================

# sha256_ctrl

Sequencing controller between the UART byte link and the SHA-256 compression core. It gathers 64 received bytes into sixteen big-endian 32-bit words and writes them into the core's block buffer. It then starts the core, captures the 256-bit digest and streams it back as 32 bytes, most significant byte first. It sits inside `SHA256_top`, between the UART RX/TX blocks and the hash core.

## Interface
- `TIMEOUT_CLKS`, default 86800: idle clocks allowed between bytes of a partial block before it is discarded (10 byte times at 868 clk/bit).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx_valid`  in  1  one-cycle pulse; `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `blk_we`  out  1  block-buffer word write strobe.
- `blk_addr`  out  4  word index 0..15.
- `blk_wdata`  out  32  packed word.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_done`  in  1  one-cycle pulse; `core_digest` is valid.
- `core_digest`  in  256  H0..H7, with H0 in bits [255:224].
- `tx_valid`  out  1  byte offered to UART TX.
- `tx_ready`  in  1  UART TX can accept a byte.
- `tx_data`  out  8  byte to transmit.
- `busy`  out  1  high while in WAIT or SEND.
- `err_drop`  out  1  one-cycle pulse when an `rx_valid` byte is discarded because the block is not in RECV.
- `err_timeout`  out  1  one-cycle pulse when a partial block is discarded on timeout.

## Operation
- States: RECV, START, WAIT, SEND.
- Reset values (async): state RECV, all counters 0, and `blk_we`, `core_start`, `tx_valid`, `busy`, `err_drop`, `err_timeout` all 0. `blk_addr`, `blk_wdata` and `tx_data` reset to 0.
- RECV, byte packing:
  - Byte count `bc` (6 bits) selects the byte lane: byte `bc` goes to word `bc>>2`, bits `[31-8*(bc%4) -: 8]`.
  - On each `rx_valid`, the byte enters the word register and `bc` increments.
  - When `bc%4==3`, `blk_we` is high in the next cycle with `blk_addr=bc>>2` and the completed word.
  - `bc` wraps 63→0; that byte moves the state to START.
- START: `blk_we` for word 15 and `core_start` are asserted in consecutive cycles (word 15, then start); then the state moves to WAIT.
- WAIT: on `core_done`, latch `core_digest` in that same edge, clear the digest byte counter `dc`, go to SEND.
- SEND:
  - `tx_valid=1` and `tx_data=digest[255-8*dc -: 8]`.
  - On `tx_valid && tx_ready`, `dc` increments.
  - After byte 31 is accepted, `tx_valid` drops in the next cycle and the state returns to RECV.
- Timeout:
  - The counter runs only in RECV with `bc!=0` and clears on every `rx_valid`.
  - When it reaches `TIMEOUT_CLKS-1`: `bc` returns to 0, `err_timeout` pulses, and no `blk_we` is issued for the partial word.
- Boundary conditions:
  - `rx_valid` in the same cycle as timeout expiry: the byte wins. It is accepted, the counter clears and there is no `err_timeout`.
  - `rx_valid` in START, WAIT or SEND: the byte is dropped and `err_drop` pulses.
  - `core_done` outside WAIT is ignored.
  - `tx_ready` low holds `tx_data` and `tx_valid` stable.
  - Reset mid-operation aborts everything; no partial output completes.

## Timing
- Latency from the last `rx_valid` (cycle T):
  - `blk_we` word 15 at T+1.
  - `core_start` at T+2.
  - `busy` is high from T+2 until the cycle after the byte-31 handshake.
- Latency from `core_done` (cycle D): first `tx_valid` at D+1.
- With `tx_ready` held high, a 32-byte burst takes exactly 32 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `sha256_pkg` holds:
  - the state enum;
  - `BLOCK_BYTES=64`, `BLOCK_WORDS=16`, `DIGEST_BYTES=32`, `WORD_W=32`.
- The timeout counter width is `$clog2(TIMEOUT_CLKS)`, local to the block.
- One sub-module, `sha256_rx_packer`, owns byte→word assembly, `bc` and the write strobe. The FSM, digest latch and TX serializer stay in `sha256_ctrl`.

## Test plan
- Send the 64 bytes of "Secure Hash Algorithm 256" (0x53 0x65 … 0x36, 0x80, zeros, final byte 0xC8):
  - word 0 = 0x53656375 at `blk_addr` 0;
  - word 15 = 0x000000C8;
  - `core_start` exactly 2 cycles after the last byte.
- Model `core_done` with digest 5f806d26…25a4a697 and `tx_ready` held high: 32 consecutive bytes 0x5f, 0x80, 0x6d, … 0x97, then `busy` low.
- Toggle `tx_ready` randomly during SEND: same byte sequence, with `tx_data` stable while stalled.
- Send 10 bytes, then idle `TIMEOUT_CLKS` cycles:
  - one `err_timeout` pulse and 2 `blk_we` in total;
  - a following full 64-byte block hashes correctly.
- Inject `rx_valid` during WAIT: `err_drop` pulses and the next block's word 0 is unaffected.
- Assert `rst_n` low in mid-SEND (byte 12): `tx_valid` goes 0 immediately and the controller is back in RECV with `bc=0`.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and sizes for the SHA-256 UART sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_RECV  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  localparam int BLOCK_BYTES  = 64;
  localparam int BLOCK_WORDS  = 16;
  localparam int DIGEST_BYTES = 32;
  localparam int WORD_W       = 32;

endpackage

// File: rtl/sha256_rx_packer.sv
// Packs received bytes into big-endian 32-bit block words and owns the byte count and inter-byte timeout.
// Latency: a completed word is written one cycle after its fourth byte is accepted.
// Backpressure: none; bytes are taken only while i_en is high and ignored otherwise.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_en high while the
// controller is in RECV; i_rx_valid/i_rx_byte incoming byte; o_bc current byte
// count; o_blk_we/o_blk_addr/o_blk_wdata block-buffer write; o_err_timeout
// one-cycle pulse when a partial block is discarded.
module sha256_rx_packer
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 86800
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_byte,
  output logic [5:0]        o_bc,
  output logic              o_blk_we,
  output logic [3:0]        o_blk_addr,
  output logic [WORD_W-1:0] o_blk_wdata,
  output logic              o_err_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT_CLKS);

  logic [5:0]        r_bc;
  logic [TMO_W-1:0]  r_tmo;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word;
  logic              w_take;
  logic              w_expire;

  assign w_take   = i_en && i_rx_valid;
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_expire = i_en && (r_bc != 6'd0) && (r_tmo == TMO_W'(TIMEOUT_CLKS - 1));
  assign o_bc     = r_bc;

  // Byte 0 of each word lands in the most significant lane.
  always_comb begin
    w_word = r_word;
    case (r_bc[1:0])
      2'd0:    w_word[31:24] = i_rx_byte;
      2'd1:    w_word[23:16] = i_rx_byte;
      2'd2:    w_word[15:8]  = i_rx_byte;
      default: w_word[7:0]   = i_rx_byte;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bc          <= '0;
      r_tmo         <= '0;
      r_word        <= '0;
      o_blk_we      <= 1'b0;
      o_blk_addr    <= '0;
      o_blk_wdata   <= '0;
      o_err_timeout <= 1'b0;
    end else begin
      o_blk_we      <= 1'b0;
      o_err_timeout <= 1'b0;
      if (w_take) begin
        r_word <= w_word;
        r_bc   <= r_bc + 6'd1;  // wraps 63 -> 0 at the end of a block
        r_tmo  <= '0;
        if (r_bc[1:0] == 2'd3) begin
          o_blk_we    <= 1'b1;
          o_blk_addr  <= r_bc[5:2];
          o_blk_wdata <= w_word;
        end
      end else if (w_expire) begin
        // Partial word is never written; stale lanes get overwritten by the next block.
        r_bc          <= '0;
        r_tmo         <= '0;
        o_err_timeout <= 1'b1;
      end else if (i_en && (r_bc != 6'd0)) begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_ctrl.sv
// Sequences UART bytes into a SHA-256 block, starts the core, and streams the 32-byte digest back out.
// Latency: word 15 write at T+1, core_start at T+2 after the last byte; first TX byte one cycle after core_done.
// Backpressure: TX holds tx_valid/tx_data while tx_ready is low; RX bytes outside RECV are dropped with err_drop.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_rx_valid/i_rx_byte
// UART RX byte; o_blk_we/o_blk_addr/o_blk_wdata block-buffer write; o_core_start,
// i_core_done/i_core_digest hash core handshake; o_tx_valid/i_tx_ready/o_tx_data
// UART TX byte; o_busy high in WAIT/SEND; o_err_drop, o_err_timeout error pulses.
module sha256_ctrl
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 86800
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_byte,
  output logic              o_blk_we,
  output logic [3:0]        o_blk_addr,
  output logic [WORD_W-1:0] o_blk_wdata,
  output logic              o_core_start,
  input  logic              i_core_done,
  input  logic [255:0]      i_core_digest,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_busy,
  output logic              o_err_drop,
  output logic              o_err_timeout
);

  state_t       r_state;
  logic [255:0] r_digest;
  logic [4:0]   r_dc;
  logic [5:0]   w_bc;
  logic         w_last;

  sha256_rx_packer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_packer (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (r_state == ST_RECV),
    .i_rx_valid    (i_rx_valid),
    .i_rx_byte     (i_rx_byte),
    .o_bc          (w_bc),
    .o_blk_we      (o_blk_we),
    .o_blk_addr    (o_blk_addr),
    .o_blk_wdata   (o_blk_wdata),
    .o_err_timeout (o_err_timeout)
  );

  assign w_last = (r_state == ST_RECV) && i_rx_valid && (w_bc == 6'(BLOCK_BYTES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RECV;
      r_digest     <= '0;
      r_dc         <= '0;
      o_core_start <= 1'b0;
      o_tx_valid   <= 1'b0;
      o_tx_data    <= '0;
      o_busy       <= 1'b0;
      o_err_drop   <= 1'b0;
    end else begin
      o_core_start <= 1'b0;
      o_err_drop   <= i_rx_valid && (r_state != ST_RECV);
      case (r_state)
        ST_RECV: begin
          if (w_last) r_state <= ST_START;
        end
        // Word 15 is being written this cycle; start follows in the next one.
        ST_START: begin
          o_core_start <= 1'b1;
          o_busy       <= 1'b1;
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_core_done) begin
            r_digest   <= i_core_digest;
            r_dc       <= '0;
            o_tx_valid <= 1'b1;
            o_tx_data  <= i_core_digest[255:248];
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // tx_valid is always high here, so tx_ready alone marks a handshake.
          // The digest register shifts left so [247:240] is always the next byte.
          if (i_tx_ready) begin
            if (r_dc == 5'(DIGEST_BYTES - 1)) begin
              o_tx_valid <= 1'b0;
              o_busy     <= 1'b0;
              r_state    <= ST_RECV;
            end else begin
              r_dc      <= r_dc + 5'd1;
              o_tx_data <= r_digest[247:240];
              r_digest  <= r_digest << 8;
            end
          end
        end
        default: r_state <= ST_RECV;
      endcase
    end
  end

endmodule
